// File: rtl/leaf_router.sv
// Group leaf router: five input FIFOs (four local NIs plus the spine uplink) feeding
// five round-robin arbitrated output registers, routed on the 6-bit flit header.
module leaf_router #(
   parameter int GROUP_ID = 4,
   parameter int DATA_W   = 16,
   parameter int IN_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [4*DATA_W-1:0] leaf_data_in,
   input  logic [3:0]          leaf_valid_in,
   output logic [3:0]          leaf_ready_out,
   output logic [4*DATA_W-1:0] leaf_data_out,
   output logic [3:0]          leaf_valid_out,
   input  logic [DATA_W-1:0]   up_data_in,
   input  logic                up_valid_in,
   output logic                up_ready_out,
   output logic [DATA_W-1:0]   up_data_out,
   output logic                up_valid_out,
   input  logic                up_ready_in,
   output logic [7:0]          drop_count
);

   localparam int         NP  = 5;
   localparam int         UP  = 4;
   localparam int         PW  = $clog2(IN_DEPTH);
   localparam int         CW  = PW + 1;
   localparam logic [3:0] GID = 4'(GROUP_ID);

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [2:0] rr_next(input logic [2:0] w);
      return (w == 3'(NP - 1)) ? 3'd0 : w + 3'd1;
   endfunction

   logic [DATA_W-1:0] r_mem_p0  [NP][IN_DEPTH];
   logic [PW-1:0]     r_wptr_p0 [NP];
   logic [PW-1:0]     r_rptr_p0 [NP];
   logic [CW-1:0]     r_cnt_p0  [NP];
   logic [NP-1:0]     r_rdy_p0;
   logic [2:0]        r_rr_ptr  [NP];
   logic [DATA_W-1:0] r_dout_p1 [NP];
   logic [NP-1:0]     r_vld_p1;
   logic [7:0]        r_drop;

   logic [DATA_W-1:0] w_din     [NP];
   logic [NP-1:0]     w_vin;
   logic [DATA_W-1:0] w_head    [NP];
   logic [NP-1:0]     w_local;
   logic [2:0]        w_dest    [NP];
   logic [NP-1:0]     w_req;
   logic [NP-1:0]     w_push;
   logic [NP-1:0]     w_pop;
   logic              w_drop;
   logic [NP-1:0]     w_gnt_vld;
   logic [2:0]        w_gnt_idx [NP];
   logic [CW-1:0]     w_cnt_nxt [NP];

   always_comb begin
      for (int i = 0; i < 4; i++) w_din[i] = leaf_data_in[i*DATA_W +: DATA_W];
      w_din[UP] = up_data_in;
      w_vin     = {up_valid_in, leaf_valid_in};
   end

   // p0: FIFO heads, routing decision and misroute detection on the uplink input
   always_comb begin
      for (int i = 0; i < NP; i++) begin
         w_head[i]  = r_mem_p0[i][r_rptr_p0[i]];
         w_local[i] = (w_head[i][DATA_W-1 -: 4] == GID);
         w_dest[i]  = w_local[i] ? {1'b0, w_head[i][DATA_W-5 -: 2]} : 3'(UP);
         w_req[i]   = (r_cnt_p0[i] != '0) && (w_local[i] || i != UP);
         w_push[i]  = w_vin[i] && (r_cnt_p0[i] < CW'(IN_DEPTH));
      end
      w_drop = (r_cnt_p0[UP] != '0) && !w_local[UP];
   end

   always_comb begin
      int idx;
      idx   = 0;
      w_pop = '0;
      for (int o = 0; o < NP; o++) begin
         w_gnt_vld[o] = 1'b0;
         w_gnt_idx[o] = '0;
         for (int k = 0; k < NP; k++) begin
            idx = int'(r_rr_ptr[o]) + k;
            if (idx >= NP) idx = idx - NP;
            if (!w_gnt_vld[o] && w_req[idx] && (w_dest[idx] == 3'(o)) &&
                (o != UP || up_ready_in)) begin
               w_gnt_vld[o] = 1'b1;
               w_gnt_idx[o] = 3'(idx);
               w_pop[idx]   = 1'b1;
            end
         end
      end
      w_pop[UP] = w_pop[UP] | w_drop;
   end

   always_comb begin
      for (int i = 0; i < NP; i++) begin
         case ({w_push[i], w_pop[i]})
            2'b10:   w_cnt_nxt[i] = r_cnt_p0[i] + CW'(1);
            2'b01:   w_cnt_nxt[i] = r_cnt_p0[i] - CW'(1);
            default: w_cnt_nxt[i] = r_cnt_p0[i];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NP; i++)
         if (w_push[i]) r_mem_p0[i][r_wptr_p0[i]] <= w_din[i];
   end

   // p1: output registers and arbiter pointers
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NP; i++) begin
            r_wptr_p0[i] <= '0;
            r_rptr_p0[i] <= '0;
            r_cnt_p0[i]  <= '0;
            r_rr_ptr[i]  <= '0;
            r_dout_p1[i] <= '0;
         end
         r_rdy_p0 <= '1;
         r_vld_p1 <= '0;
         r_drop   <= '0;
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (w_push[i]) r_wptr_p0[i] <= r_wptr_p0[i] + PW'(1);
            if (w_pop[i])  r_rptr_p0[i] <= r_rptr_p0[i] + PW'(1);
            r_cnt_p0[i] <= w_cnt_nxt[i];
            r_rdy_p0[i] <= (w_cnt_nxt[i] <= CW'(IN_DEPTH - 2));
            r_vld_p1[i] <= w_gnt_vld[i];
            if (w_gnt_vld[i]) begin
               r_dout_p1[i] <= w_head[w_gnt_idx[i]];
               r_rr_ptr[i]  <= rr_next(w_gnt_idx[i]);
            end
         end
         if (w_drop) r_drop <= sat_inc8(r_drop);
      end
   end

   always_comb begin
      leaf_data_out = '0;
      for (int o = 0; o < 4; o++) leaf_data_out[o*DATA_W +: DATA_W] = r_dout_p1[o];
   end

   assign leaf_valid_out = r_vld_p1[3:0];
   assign leaf_ready_out = r_rdy_p0[3:0];
   assign up_data_out    = r_dout_p1[UP];
   assign up_valid_out   = r_vld_p1[UP];
   assign up_ready_out   = r_rdy_p0[UP];
   assign drop_count     = r_drop;

endmodule

// File: doc/leaf_router.md
# leaf_router

Group-level leaf router that sits directly on the router side of the four per-GPU network interfaces of one group. It accepts single-flit 16-bit packets from the four local NIs and from one uplink to the spine. Each flit is routed on its 6-bit routing header (4-bit group, 2-bit leaf) to a local NI or to the uplink. Each input is buffered, each output has round-robin arbitration, and the uplink uses a valid/ready handshake.

## Interface
- GROUP_ID, 4: 4-bit group number; header[15:12] equal to this value means the destination is local.
- DATA_W, 16: flit width; header is bits [15:10].
- IN_DEPTH, 4: entries per input FIFO; must be a power of 2 and at least 2.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- leaf_data_in  in  4*DATA_W  flit from local NI i, in slice [16i+15:16i].
- leaf_valid_in  in  4  flit i valid.
- leaf_ready_out  out  4  input i can accept a flit next cycle.
- leaf_data_out  out  4*DATA_W  flit to local NI i.
- leaf_valid_out  out  4  one-cycle pulse per flit delivered to NI i.
- up_data_in  in  DATA_W  flit from spine.
- up_valid_in  in  1  spine flit valid.
- up_ready_out  out  1  uplink input can accept.
- up_data_out  out  DATA_W  flit to spine.
- up_valid_out  out  1  flit to spine valid.
- up_ready_in  in  1  spine can accept.
- drop_count  out  8  count of misrouted uplink flits; saturates at 255.

## Operation
- Inputs 0–3 are the leaves; input 4 is the uplink. Each input has its own FIFO of IN_DEPTH entries, with count width log2(IN_DEPTH)+1. Pointers wrap modulo IN_DEPTH.
- A flit is written when valid is high and count < IN_DEPTH. A flit presented while the FIFO is full is lost. The ready rule below prevents this for compliant senders.
- ready_out = (count <= IN_DEPTH-2), registered. Ready deasserts with one slot still free, so a sender that saw ready one cycle earlier can still land its flit.
- Routing of the head flit h:
  - If h[15:12] == GROUP_ID, the destination is leaf h[11:10].
  - Otherwise the destination is the uplink.
  - A leaf-to-same-leaf flit is legal and is delivered back to that leaf.
  - A flit at the uplink input whose group is not GROUP_ID would be routed back up. Instead it is popped and discarded, and drop_count increments.
- Arbitration: one round-robin arbiter per output, with 5 requesters.
  - The requester after the last winner has highest priority.
  - The pointer advances to winner+1 (mod 5) only when a grant is made.
  - The uplink arbiter grants only when up_ready_in = 1 in that cycle.
  - Each input requests exactly one output per cycle, so an input is granted by at most one arbiter. A granted input pops its head.
- Output registers:
  - The winner's flit is registered into the output data register and valid is set for one cycle.
  - With no grant, valid is 0 and data holds its last value.
  - Leaf outputs have no backpressure, because the NI accepts or drops.
  - Flits are passed unmodified; the header is not rewritten.
- Reset clears all FIFO pointers and counts, arbiter pointers (to 0), drop_count, and all valid outputs. leaf_ready_out and up_ready_out go to 1, leaf_data_out and up_data_out go to 0. In-flight FIFO contents are discarded when reset is asserted mid-traffic.

## Timing
- Cycle T: valid_in sampled high, so the flit is written.
- Cycle T+1: the flit is at the FIFO head and arbitrated.
- Cycle T+2: output valid is high, for an uncontested flit.
- Contention: N inputs targeting one output are served in N consecutive cycles in round-robin order. Each loser's head stalls and blocks its own FIFO (head-of-line blocking is accepted).
- Throughput: one flit per output per cycle, up to 5 flits per cycle in total.
- Simultaneous push and pop on one FIFO in the same cycle leaves the count unchanged.
- ready_out reflects the count after the current cycle's push and pop, visible the next cycle.
- Uplink stall: while up_ready_in = 0, no uplink grant is made, up_valid_out = 0, and uplink-bound heads wait.
- drop_count increments at most once per cycle, because only the uplink input can drop. It holds at 255.

## Test plan
- Route local: after reset, leaf 0 sends 0x4C05 (group 4, leaf 3) in cycle 2 -> leaf_valid_out[3] = 1 with data 0x4C05 in cycle 4, and no other valid outputs.
- Route up: leaf 1 sends 0x2001 (group 2) with up_ready_in = 1 -> up_data_out = 0x2001 two cycles later. Repeat with up_ready_in = 0 for 5 cycles -> held, then delivered on the cycle after up_ready_in rises.
- Fairness: leaves 0–3 and the uplink all send a flit to leaf 2 (0x48xx) in the same cycle -> leaf_valid_out[2] pulses 5 consecutive cycles, with sources in order 0,1,2,3,uplink. A second burst starts from the winner after the last one.
- Backpressure: up_ready_in = 0, leaf 0 streams uplink-bound flits every cycle it sees ready -> leaf_ready_out[0] drops after 3 accepted, no flit lost. Releasing up_ready_in delivers all flits in order.
- Misroute drop: uplink sends 0x1000, 0x3400 -> nothing output, drop_count = 2. Send 300 such flits -> drop_count = 255.
- Reset mid-traffic: assert reset with 3 flits buffered -> next cycle all valids 0, ready 1, drop_count 0, and no stale flits emerge afterwards.
